// File: rtl/game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg: scene codes, tile IDs, colour key and fade types shared by the
// address generator and the pixel compositor.            Rev 1.0
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [3:0] SC_START = 4'd0;
  localparam logic [3:0] SC_PLAY  = 4'd1;
  localparam logic [3:0] SC_LOSE  = 4'd2;
  localparam logic [3:0] SC_WIN   = 4'd3;
  localparam logic [3:0] SC_BOSS  = 4'd4;

  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_SPIKE  = 4'd1;
  localparam logic [3:0] TILE_GATE_1 = 4'd2;
  localparam logic [3:0] TILE_GATE_2 = 4'd3;
  localparam logic [3:0] TILE_GATE_3 = 4'd4;
  localparam logic [3:0] TILE_LADDER = 4'd5;
  localparam logic [3:0] TILE_KEY    = 4'd6;
  localparam logic [3:0] TILE_DOOR   = 4'd7;
  localparam logic [3:0] TILE_FLOOR  = 4'd8;
  localparam logic [3:0] TILE_WALL   = 4'd9;

  localparam logic [11:0] COLOR_KEY_DEFAULT = 12'hF0F;

  localparam int FADE_W = 5;
  localparam logic [FADE_W-1:0] FADE_MAX = 5'd16;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_WAIT = 2'd2,
    FADE_IN   = 2'd3
  } fade_state_e;

  // One pipeline stage of the T0-side delay line.
  typedef struct packed {
    logic active;
    logic top;
    logic hs;
    logic vs;
  } tap_t;

  // (c * L) >> 4; L = 16 is identity, so the product never exceeds 8 bits.
  function automatic logic [3:0] fade_channel(input logic [3:0] c,
                                              input logic [FADE_W-1:0] lvl);
    logic [7:0] prod;
    prod = 8'(c) * 8'(lvl);
    return prod[7:4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fade_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fade_ctrl: vsync-paced fade level sequencer for scene changes.  Rev 1.0
// ---------------------------------------------------------------------------
module fade_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic [3:0]        state,
  input  logic [3:0]        next_state,
  output logic [FADE_W-1:0] level,
  output logic              fade_done,
  output logic              fading
);

  localparam logic [3:0] C_STEP_LAST = 4'(FRAMES_PER_STEP - 1);

  fade_state_e       r_fsm, w_fsm_nxt;
  logic [FADE_W-1:0] r_level, w_level_nxt;
  logic [3:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic              r_vs_prev;
  logic              r_fade_done, w_fade_done_nxt;
  logic              w_tick, w_step, w_req;

  assign w_tick = vsync_in & ~r_vs_prev;
  assign w_step = w_tick && (r_frame_cnt == C_STEP_LAST);
  assign w_req  = (next_state != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= FADE_IDLE;
      r_level     <= FADE_MAX;
      r_frame_cnt <= '0;
      r_vs_prev   <= 1'b1;
      r_fade_done <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_level     <= w_level_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_vs_prev   <= vsync_in;
      r_fade_done <= w_fade_done_nxt;
    end
  end

  // A request change always wins over a simultaneous step: L holds that cycle.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_level_nxt     = r_level;
    w_fade_done_nxt = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_tick) begin
      w_frame_cnt_nxt = w_step ? 4'd0 : r_frame_cnt + 4'd1;
    end
    case (r_fsm)
      FADE_IDLE: begin
        w_level_nxt = FADE_MAX;
        if (w_req) w_fsm_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        if (!w_req) begin
          w_fsm_nxt = FADE_IN;
        end else if (w_step) begin
          if (r_level <= 5'd1) begin
            w_level_nxt     = '0;
            w_fsm_nxt       = FADE_WAIT;
            w_fade_done_nxt = 1'b1;
          end else begin
            w_level_nxt = r_level - 5'd1;
          end
        end
      end
      FADE_WAIT: begin
        w_level_nxt = '0;
        if (!w_req) w_fsm_nxt = FADE_IN;
      end
      FADE_IN: begin
        if (w_req) begin
          w_fsm_nxt = FADE_OUT;
        end else if (w_step) begin
          w_level_nxt = r_level + 5'd1;
          if (r_level >= FADE_MAX - 5'd1) begin
            w_level_nxt = FADE_MAX;
            w_fsm_nxt   = FADE_IDLE;
          end
        end
      end
      default: begin
        w_fsm_nxt   = FADE_IDLE;
        w_level_nxt = FADE_MAX;
      end
    endcase
    if (w_fsm_nxt != r_fsm) w_frame_cnt_nxt = '0;
  end

  assign level     = r_level;
  assign fade_done = r_fade_done;
  assign fading    = (r_fsm != FADE_IDLE);

endmodule
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_compositor: resolves sprite/tile colour, delays syncs and applies the
// scene fade before driving the VGA pins.                 Rev 1.0
// ---------------------------------------------------------------------------
module pixel_compositor
  import game_pkg::*;
#(
  parameter logic [11:0] COLOR_KEY       = COLOR_KEY_DEFAULT,
  parameter logic [11:0] BG_PLAY         = 12'h000,
  parameter int          FRAMES_PER_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] pixel_data,
  input  logic        show_pixel,
  input  logic [3:0]  tile_id,
  input  logic        is_char_sync,
  input  logic        is_char_sync_1,
  input  logic [4:0]  gate_open,
  input  logic        spike_on,
  input  logic [3:0]  state,
  input  logic [3:0]  next_state,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        fade_done,
  output logic        fading
);

  localparam tap_t C_TAP_RESET = '{active: 1'b0, top: 1'b0, hs: 1'b1, vs: 1'b1};

  tap_t              r_tap [3];
  tap_t              w_tap_in;
  logic [FADE_W-1:0] w_level;
  logic [11:0]       w_color;
  logic              w_char, w_gate_hit, w_tile_vis;
  logic              w_unused_gate;

  assign w_tap_in.active = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign w_tap_in.top    = (v_cnt < 10'd256);
  assign w_tap_in.hs     = hsync_in;
  assign w_tap_in.vs     = vsync_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_tap[i] <= C_TAP_RESET;
    end else begin
      r_tap[0] <= w_tap_in;
      for (int i = 1; i < 3; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  // Gate-open bits 4/3/2 map to gates 1/2/3; the low two bits carry no gate.
  assign w_unused_gate = ^gate_open[1:0];
  assign w_char        = is_char_sync | is_char_sync_1;
  assign w_gate_hit    = ((tile_id == TILE_GATE_1) && gate_open[4]) ||
                         ((tile_id == TILE_GATE_2) && gate_open[3]) ||
                         ((tile_id == TILE_GATE_3) && gate_open[2]);
  assign w_tile_vis    = (tile_id != TILE_EMPTY) && !w_gate_hit &&
                         !((tile_id == TILE_SPIKE) && !spike_on);

  always_comb begin
    w_color = BG_PLAY;
    if (!r_tap[2].active) begin
      w_color = 12'h000;
    end else begin
      case (state)
        SC_START, SC_LOSE, SC_WIN: w_color = pixel_data;
        SC_PLAY, SC_BOSS: begin
          if ((state == SC_BOSS) && r_tap[2].top)      w_color = pixel_data;
          else if (w_char && (pixel_data != COLOR_KEY)) w_color = pixel_data;
          else if (show_pixel && w_tile_vis)            w_color = pixel_data;
          else                                          w_color = BG_PLAY;
        end
        default: w_color = BG_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_red   <= 4'h0;
      vga_green <= 4'h0;
      vga_blue  <= 4'h0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      vga_red   <= fade_channel(w_color[11:8], w_level);
      vga_green <= fade_channel(w_color[7:4],  w_level);
      vga_blue  <= fade_channel(w_color[3:0],  w_level);
      hsync     <= r_tap[2].hs;
      vsync     <= r_tap[2].vs;
    end
  end

  fade_ctrl #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_fade_ctrl (
    .clk       (clk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .state     (state),
    .next_state(next_state),
    .level     (w_level),
    .fade_done (fade_done),
    .fading    (fading)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pixel_compositor: vector table, random model compare and fade sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pixel_compositor;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic [3:0]  state;
    logic [3:0]  next;
    logic [11:0] pix;
    logic        show;
    logic [3:0]  tile;
    logic        c0;
    logic        c1;
    logic [4:0]  gate;
    logic        spike;
  } in_t;

  typedef struct {
    logic [3:0]  state;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [11:0] pix;
    logic        show;
    logic [3:0]  tile;
    logic        c0;
    logic        c1;
    logic [4:0]  gate;
    logic        spike;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  in_t  hist [8];
  logic [3:0] vga_red, vga_green, vga_blue;
  logic hsync, vsync, fade_done, fading;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int done_pulses = 0;
  bit model_on = 1'b0;
  int model_start = 0;
  vec_t vecs [18];

  always #20 clk = ~clk;

  pixel_compositor #(
    .COLOR_KEY      (12'hF0F),
    .BG_PLAY        (12'h000),
    .FRAMES_PER_STEP(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .h_cnt         (cur.h),
    .v_cnt         (cur.v),
    .hsync_in      (cur.hs),
    .vsync_in      (cur.vs),
    .pixel_data    (cur.pix),
    .show_pixel    (cur.show),
    .tile_id       (cur.tile),
    .is_char_sync  (cur.c0),
    .is_char_sync_1(cur.c1),
    .gate_open     (cur.gate),
    .spike_on      (cur.spike),
    .state         (cur.state),
    .next_state    (cur.next),
    .vga_red       (vga_red),
    .vga_green     (vga_green),
    .vga_blue      (vga_blue),
    .hsync         (hsync),
    .vsync         (vsync),
    .fade_done     (fade_done),
    .fading        (fading)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Colour the screen should show, from the raw counters seen three edges
  // earlier and the generator outputs presented alongside (full brightness).
  function automatic logic [11:0] ref_color(input in_t t0, input in_t t3);
    bit vis;
    if (!(t0.h < 640 && t0.v < 480)) return 12'h000;
    if (t3.state == 0 || t3.state == 2 || t3.state == 3) return t3.pix;
    if (t3.state == 4 && t0.v < 256) return t3.pix;
    if (t3.state != 1 && t3.state != 4) return 12'h000;
    if ((t3.c0 || t3.c1) && t3.pix != 12'hF0F) return t3.pix;
    vis = (t3.tile != 0);
    if (t3.tile >= 2 && t3.tile <= 4 && t3.gate[6 - t3.tile]) vis = 1'b0;
    if (t3.tile == 1 && !t3.spike) vis = 1'b0;
    if (t3.show && vis) return t3.pix;
    return 12'h000;
  endfunction

  // Inputs set now are captured at the next rising edge; outputs are sampled
  // on the following falling edge.
  task automatic cyc();
    logic [11:0] exp;
    hist[n % 8] = cur;
    @(posedge clk);
    @(negedge clk);
    if (fade_done) done_pulses++;
    if (model_on && n >= model_start + 3) begin
      exp = ref_color(hist[(n - 3) % 8], hist[n % 8]);
      check("rand_rgb", {20'h0, vga_red, vga_green, vga_blue}, {20'h0, exp});
      check("rand_hsync", {31'h0, hsync}, {31'h0, hist[(n - 3) % 8].hs});
      check("rand_vsync", {31'h0, vsync}, {31'h0, hist[(n - 3) % 8].vs});
    end
    n++;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  // One frame tick: a vsync_in rising edge, then let the new level reach the pins.
  task automatic vtick();
    cur.vs = 1'b0;
    cycles(2);
    cur.vs = 1'b1;
    cycles(4);
  endtask

  function automatic logic [31:0] grey(input int lvl);
    logic [3:0] ch;
    ch = 4'((15 * lvl) >> 4);
    return {20'h0, ch, ch, ch};
  endfunction

  function automatic vec_t mk(input logic [3:0] st, input logic [9:0] h, input logic [9:0] v,
                              input logic [11:0] pix, input logic show, input logic [3:0] tile,
                              input logic c0, input logic c1, input logic [4:0] gate,
                              input logic spike, input logic [11:0] exp);
    vec_t r;
    r.state = st; r.h = h; r.v = v; r.pix = pix; r.show = show; r.tile = tile;
    r.c0 = c0; r.c1 = c1; r.gate = gate; r.spike = spike; r.exp = exp;
    return r;
  endfunction

  initial begin
    vecs[0]  = mk(4'd1, 10'd0,   10'd0,   12'hF0F, 0, 4'd0, 1, 0, 5'b00000, 1, 12'h000);
    vecs[1]  = mk(4'd1, 10'd0,   10'd0,   12'h3A5, 0, 4'd0, 1, 0, 5'b00000, 1, 12'h3A5);
    vecs[2]  = mk(4'd1, 10'd5,   10'd5,   12'h3A5, 0, 4'd0, 0, 1, 5'b00000, 1, 12'h3A5);
    vecs[3]  = mk(4'd1, 10'd10,  10'd10,  12'hFFF, 1, 4'd3, 0, 0, 5'b01000, 1, 12'h000);
    vecs[4]  = mk(4'd1, 10'd10,  10'd10,  12'hFFF, 1, 4'd3, 0, 0, 5'b00000, 1, 12'hFFF);
    vecs[5]  = mk(4'd1, 10'd10,  10'd10,  12'hFFF, 1, 4'd1, 0, 0, 5'b00000, 0, 12'h000);
    vecs[6]  = mk(4'd1, 10'd10,  10'd10,  12'hFFF, 1, 4'd1, 0, 0, 5'b00000, 1, 12'hFFF);
    vecs[7]  = mk(4'd1, 10'd640, 10'd10,  12'hFFF, 1, 4'd9, 1, 0, 5'b00000, 1, 12'h000);
    vecs[8]  = mk(4'd4, 10'd20,  10'd100, 12'h123, 0, 4'd0, 0, 0, 5'b00000, 1, 12'h123);
    vecs[9]  = mk(4'd4, 10'd20,  10'd300, 12'h123, 0, 4'd0, 0, 0, 5'b00000, 1, 12'h000);
    vecs[10] = mk(4'd0, 10'd0,   10'd0,   12'hABC, 0, 4'd0, 0, 0, 5'b00000, 1, 12'hABC);
    vecs[11] = mk(4'd3, 10'd639, 10'd479, 12'h456, 0, 4'd0, 0, 0, 5'b00000, 1, 12'h456);
    vecs[12] = mk(4'd2, 10'd100, 10'd480, 12'h456, 0, 4'd0, 0, 0, 5'b00000, 1, 12'h000);
    vecs[13] = mk(4'd7, 10'd100, 10'd100, 12'h456, 1, 4'd9, 1, 0, 5'b00000, 1, 12'h000);
    vecs[14] = mk(4'd1, 10'd30,  10'd30,  12'h777, 1, 4'd2, 0, 0, 5'b10000, 1, 12'h000);
    vecs[15] = mk(4'd1, 10'd30,  10'd30,  12'h777, 1, 4'd4, 0, 0, 5'b00100, 1, 12'h000);
    vecs[16] = mk(4'd1, 10'd30,  10'd30,  12'h777, 1, 4'd4, 0, 0, 5'b11011, 1, 12'h777);
    vecs[17] = mk(4'd1, 10'd30,  10'd30,  12'h777, 0, 4'd5, 0, 0, 5'b00000, 1, 12'h000);

    cur = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, state: 4'd0, next: 4'd0,
            pix: 12'h000, show: 1'b0, tile: 4'd0, c0: 1'b0, c1: 1'b0,
            gate: 5'b0, spike: 1'b1};
    for (int i = 0; i < 8; i++) hist[i] = cur;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rgb", {20'h0, vga_red, vga_green, vga_blue}, 32'h0);
    check("rst_hsync", {31'h0, hsync}, 32'h1);
    check("rst_vsync", {31'h0, vsync}, 32'h1);
    check("rst_fade_done", {31'h0, fade_done}, 32'h0);
    check("rst_fading", {31'h0, fading}, 32'h0);
    rst = 1'b0;
    cycles(2);

    // Vector table: hold each input set until the pipeline is full, then compare.
    for (int i = 0; i < 18; i++) begin
      cur.state = vecs[i].state; cur.next = vecs[i].state;
      cur.h = vecs[i].h; cur.v = vecs[i].v; cur.pix = vecs[i].pix;
      cur.show = vecs[i].show; cur.tile = vecs[i].tile;
      cur.c0 = vecs[i].c0; cur.c1 = vecs[i].c1;
      cur.gate = vecs[i].gate; cur.spike = vecs[i].spike;
      cycles(5);
      check($sformatf("vec%0d_rgb", i), {20'h0, vga_red, vga_green, vga_blue},
            {20'h0, vecs[i].exp});
    end

    // hsync_in falls in cycle n; hsync must fall in cycle n+4.
    cur.hs = 1'b1;
    cycles(5);
    cur.hs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("hsync_lat_%0d", k), {31'h0, hsync}, (k < 4) ? 32'h1 : 32'h0);
    end
    cur.hs = 1'b1;
    cycles(5);

    // Randomised traffic with no scene change requested.
    model_on = 1'b1;
    model_start = n;
    for (int i = 0; i < 400; i++) begin
      cur.h = 10'($urandom_range(0, 799));
      cur.v = 10'($urandom_range(0, 524));
      cur.hs = 1'($urandom);
      cur.vs = 1'($urandom);
      if (i % 16 == 0) cur.state = 4'($urandom_range(0, 7));
      cur.next = cur.state;
      cur.pix = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
      cur.show = 1'($urandom);
      cur.tile = 4'($urandom_range(0, 9));
      cur.c0 = ($urandom_range(0, 3) == 0);
      cur.c1 = ($urandom_range(0, 3) == 0);
      cur.gate = 5'($urandom);
      cur.spike = 1'($urandom);
      cyc();
    end
    model_on = 1'b0;

    // Full fade out to black and back in, one frame per level step.
    cur = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, state: 4'd0, next: 4'd0,
            pix: 12'hFFF, show: 1'b0, tile: 4'd0, c0: 1'b1, c1: 1'b0,
            gate: 5'b0, spike: 1'b1};
    cycles(6);
    check("idle_rgb", {20'h0, vga_red, vga_green, vga_blue}, grey(16));
    check("idle_fading", {31'h0, fading}, 32'h0);
    cur.next = 4'd1;
    cycles(2);
    done_pulses = 0;
    check("fade_start_fading", {31'h0, fading}, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      vtick();
      check($sformatf("fade_out_L%0d", 16 - k), {20'h0, vga_red, vga_green, vga_blue},
            grey(16 - k));
    end
    cycles(3);
    check("fade_done_once", done_pulses, 32'd1);
    check("wait_fading", {31'h0, fading}, 32'h1);
    cur.state = 4'd1;
    for (int k = 1; k <= 16; k++) begin
      vtick();
      check($sformatf("fade_in_L%0d", k), {20'h0, vga_red, vga_green, vga_blue}, grey(k));
    end
    cycles(2);
    check("fade_in_end_fading", {31'h0, fading}, 32'h0);
    check("fade_in_no_extra_done", done_pulses, 32'd1);

    // Abort at L=9: level climbs back with no fade_done.
    cur.next = 4'd0;
    cycles(2);
    done_pulses = 0;
    for (int k = 1; k <= 7; k++) vtick();
    check("abort_L9", {20'h0, vga_red, vga_green, vga_blue}, grey(9));
    cur.next = 4'd1;
    for (int lv = 10; lv <= 16; lv++) begin
      vtick();
      check($sformatf("abort_up_L%0d", lv), {20'h0, vga_red, vga_green, vga_blue}, grey(lv));
    end
    cycles(2);
    check("abort_no_done", done_pulses, 32'd0);
    check("abort_end_fading", {31'h0, fading}, 32'h0);

    // Reset at L=5 returns straight to IDLE at full brightness.
    cur.next = 4'd0;
    cycles(2);
    for (int k = 1; k <= 11; k++) vtick();
    check("pre_rst_L5", {20'h0, vga_red, vga_green, vga_blue}, grey(5));
    cur.next = 4'd1;
    rst = 1'b1;
    #1;
    check("mid_rst_fading", {31'h0, fading}, 32'h0);
    check("mid_rst_rgb", {20'h0, vga_red, vga_green, vga_blue}, 32'h0);
    check("mid_rst_hsync", {31'h0, hsync}, 32'h1);
    #5;
    rst = 1'b0;
    cycles(4);
    check("post_rst_rgb", {20'h0, vga_red, vga_green, vga_blue}, grey(16));
    check("post_rst_fading", {31'h0, fading}, 32'h0);
    check("post_rst_fade_done", {31'h0, fade_done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_compositor.md
# pixel_compositor

Downstream stage of the sprite/tile address generator: consumes the 12-bit RGB444 word returned by the image BRAM together with the generator's aligned tile ID and character flags, then resolves transparency, open gates, inactive spikes and background. Also delays hsync/vsync to match the pixel pipeline and applies a per-frame fade-out/fade-in across scene changes. It drives the VGA pins directly.

## Interface
Parameters:
- `COLOR_KEY`, 12'hF0F: transparent colour in character sprites.
- `BG_PLAY`, 12'h000: background colour for PLAY and BOSS scenes.
- `FRAMES_PER_STEP`, 2: frames per fade level step (range 1..15).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: 25 MHz pixel clock.
- `rst`  in  1: async active-high reset.
- `h_cnt`, `v_cnt`  in  10 each: raw VGA counters (cycle T0).
- `hsync_in`, `vsync_in`  in  1 each: raw VGA syncs (T0).
- `pixel_data`  in  12: BRAM output (T3).
- `show_pixel`  in  1: generator show flag (T3).
- `tile_id`  in  4: aligned tile ID (T3).
- `is_char_sync`, `is_char_sync_1`  in  1 each: aligned character flags (T3).
- `gate_open`  in  5: bit 4/3/2 opens gate 1/2/3.
- `spike_on`  in  1: spikes visible.
- `state`, `next_state`  in  4: current and requested scene codes.
- `vga_red`, `vga_green`, `vga_blue`  out  4 each: colour.
- `hsync`, `vsync`  out  1 each: delayed syncs.
- `fade_done`  out  1: one-cycle pulse when the screen is fully black and waiting for the scene commit.
- `fading`  out  1: high whenever FSM is not in IDLE.

## Operation
**T0-side delay line.** A 3-stage shift register carries:
- `active = h_cnt<640 && v_cnt<480`
- `top = v_cnt<256`
- `hsync_in`, `vsync_in`

The stage-3 taps are aligned with T3 inputs.

**Colour select at T3**, first match wins:
1. `!active`: 12'h000.
2. `state` is START(0), LOSE(2) or WIN(3): `pixel_data`.
3. `state` is BOSS(4) and `top`: `pixel_data`.
4. Character flag set and `pixel_data != COLOR_KEY`: `pixel_data`.
5. `show_pixel`, tile visible: `pixel_data`. A tile is visible if `tile_id` is nonzero and is not an open gate (GATE_1..3 = 2..4 with the matching `gate_open` bit set) and is not a SPIKE (1) with `!spike_on`.
6. Otherwise: `BG_PLAY`.

For any other `state` code, the output is `BG_PLAY` in the active area.

**Fade.** Fade level L is 5 bits, 0..16. Each output channel = (c·L)>>4, so L=16 is identity and L=0 is black. A frame tick is the rising edge of `vsync_in` detected in the `clk` domain. A step occurs every `FRAMES_PER_STEP` ticks via a frame counter that is cleared on every state entry.

**FSM states:**
- **IDLE** (L=16): goes to FADE_OUT when `next_state != state`.
- **FADE_OUT**: L decrements one per step.
  - At L=0: pulse `fade_done`, go to WAIT.
  - If `next_state == state` before L reaches 0: go to FADE_IN from the current L.
- **WAIT** (L=0): when `state == next_state` (top has committed), go to FADE_IN.
- **FADE_IN**: L increments one per step.
  - At L=16: go to IDLE.
  - If `next_state != state`: go to FADE_OUT from the current L.

## Timing
- Colour, `hsync` and `vsync` are all registered once after T3. They appear at T4 relative to `h_cnt`, `v_cnt` and the raw syncs, a 4-cycle sync latency.
- L updates on the cycle after a step tick. New L applies from the next pixel with no mid-pixel glitch.
- `fade_done` is high for exactly one `clk` cycle, on the cycle the FSM enters WAIT.
- Reset values:
  - colour = 0; `hsync` = 1, `vsync` = 1; all delay stages = 0 with sync stages = 1.
  - L = 16, FSM = IDLE, frame counter = 0, `fade_done` = 0, `fading` = 0.
- Reset mid-fade: immediate return to IDLE with L=16.
- A step tick and a request change in the same cycle: the transition takes priority and L does not move that cycle.

## Structure
- Shared package `game_pkg` holds:
  - scene codes (START/PLAY/LOSE/WIN/BOSS);
  - tile IDs (EMPTY..WALL, 0..9);
  - `COLOR_KEY` default;
  - the fade-level width.
- The address generator imports the same package.
- Sub-module `fade_ctrl` contains the vsync edge detect, frame counter, FSM, L, `fade_done` and `fading`.
- The top level contains the delay line, colour mux and multiply-shift.

## Test plan
- **PLAY, key masking.** `is_char_sync`=1 with `pixel_data`=12'hF0F: colour 000 (`BG_PLAY`). With `pixel_data`=12'h3A5: colour 3,A,5 at T4.
- **Gate and spike masking.** `tile_id`=3, `gate_open`=5'b01000, `show_pixel`=1, `pixel_data`=12'hFFF: colour 000. Clearing bit 3 gives FFF. `tile_id`=1 with `spike_on`=0 gives 000.
- **Blanking and sync delay.** `h_cnt`=640 gives 000. A `hsync_in` falling edge at cycle n gives a `hsync` falling edge at cycle n+4.
- **BOSS split.** `state`=4, `v_cnt`=100, `show_pixel`=0, `pixel_data`=12'h123: colour 1,2,3. With `v_cnt`=300 and no flags: 000.
- **Full fade, `FRAMES_PER_STEP`=1.**
  - `next_state`: 0→1 at `state`=0. Colour 12'hFFF sequences F,E,D…0 over 16 vsync ticks, then `fade_done` pulses once.
  - `state`←1: colour rises back to F after 16 ticks, then `fading`=0.
- **Abort and reset.**
  - `next_state` returns to `state` at L=9: L climbs 10..16 with no `fade_done`.
  - `rst` at L=5: L=16 and IDLE immediately.
